pix_stream_tx: RTL
==================

PIX_STREAM_TX -- requirements
Module: pix_stream_tx

Interface
REQ-001 Parameter IMG_HDISP, default 640, active pixels per line.
REQ-002 Parameter IMG_VDISP, default 480, active lines per frame.
REQ-003 Parameter H_BLANK, default 16, idle cycles after each active line.
REQ-004 Parameter V_SYNC, default 2, cycles vsync held high at frame start.
REQ-005 Parameter V_BLANK, default 4, idle cycles after vsync and after the last line.
REQ-006 Parameter CLKEN_GAP, default 0, idle cycles inserted between consecutive valid pixels within a line (0 = one pixel every cycle).
REQ-007 Port clock, input, 1, sole clock, rising edge.
REQ-008 Port rst_n, input, 1, asynchronous active-low reset.
REQ-009 Port start, input, 1, single-cycle request to send one frame.
REQ-010 Port mem_rd_addr, output, ADDR_W, frame-memory read address, where ADDR_W = ceil(log2(IMG_HDISP*IMG_VDISP)).
REQ-011 Port mem_rd_data, input, 8, frame-memory read data, valid one cycle after its address.
REQ-012 Port post_frame_vsync, output, 1, frame sync.
REQ-013 Port post_frame_href, output, 1, high across each active line, including CLKEN_GAP cycles.
REQ-014 Port post_frame_clken, output, 1, pixel-valid qualifier.
REQ-015 Port post_img_Y, output, 8, pixel data.
REQ-016 Port busy, output, 1, high from accepted start until the end of V_FRONT.
REQ-017 Port frame_done, output, 1, one-cycle pulse on the last V_FRONT cycle.

Function
REQ-018 FSM states: IDLE, VSYNC, V_BACK, ACTIVE, H_GAP, V_FRONT.
REQ-019 IDLE -> VSYNC when start=1; start is ignored while busy=1.
REQ-020 VSYNC lasts V_SYNC cycles with post_frame_vsync=1, then goes to V_BACK.
REQ-021 V_BACK lasts V_BLANK cycles, then goes to ACTIVE.
REQ-022 ACTIVE issues IMG_HDISP reads at addresses line*IMG_HDISP+col; each read is followed by CLKEN_GAP idle cycles, except the last read of a line.
REQ-023 After the last pixel of a line, the FSM goes to H_GAP for H_BLANK cycles if lines remain, otherwise to V_FRONT.
REQ-024 H_GAP -> ACTIVE with the line counter incremented and the column counter cleared.
REQ-025 V_FRONT lasts V_BLANK cycles, pulses frame_done in its last cycle, then returns to IDLE.
REQ-026 Latency: post_frame_href, post_frame_clken and post_img_Y are registered one cycle after the internal read strobe, so post_img_Y equals mem_rd_data for the address issued in the previous cycle.
REQ-027 Output counts per frame: exactly IMG_VDISP href pulses; exactly IMG_HDISP clken cycles per href pulse; href width = IMG_HDISP + (IMG_HDISP-1)*CLKEN_GAP cycles.
REQ-028 When post_frame_clken=0, post_img_Y = 0.
REQ-029 mem_rd_addr holds its last value when no read is issued.
REQ-030 Counters wrap only through explicit clears; the address never exceeds IMG_HDISP*IMG_VDISP-1.
REQ-031 start asserted in the same cycle as frame_done is ignored; a new frame needs start while in IDLE.

Reset
REQ-032 rst_n=0 at any time, including mid-frame, forces IDLE and clears all counters immediately.
REQ-033 While rst_n=0, all outputs are 0: vsync, href, clken, post_img_Y, mem_rd_addr, busy, frame_done.
REQ-034 After rst_n is released, no output activity occurs until a start pulse is accepted.

Structure
REQ-035 A shared package holds the FSM state enumeration and the default timing constants (IMG_HDISP, IMG_VDISP, H_BLANK, V_SYNC, V_BLANK).
REQ-036 ADDR_W is derived locally by a ceil-log2 function.
REQ-037 One sub-module, pix_tx_timing, contains the FSM and the counters; the top level contains only the memory-read alignment register.

Verification
REQ-038 IMG_HDISP=8, IMG_VDISP=4, CLKEN_GAP=0, memory pattern data=addr[7:0], start pulse -> 4 href pulses of 8 cycles each, post_img_Y = 0..31 in order, H_BLANK gaps of 16 cycles, then one frame_done pulse.
REQ-039 Same configuration with CLKEN_GAP=2 -> href width 22 cycles, clken high every 3rd cycle, 8 pixels per line.
REQ-040 start re-pulsed during ACTIVE -> ignored; the frame completes with exactly 32 pixels and one frame_done.
REQ-041 rst_n asserted during line 2 -> all outputs 0 in the same cycle; after release, a start pulse yields a full frame that begins at address 0.
REQ-042 Back-to-back frames with start issued the cycle after frame_done -> the second frame is identical to the first, with vsync high for 2 cycles.
REQ-043 Loopback of the output stream into the line-shift RAM consumer with IMG_HDISP=8 -> taps match the pixel values of the previous and prior-previous line.

Source files
------------

// File: rtl/pix_stream_tx_pkg.sv
// Shared definitions for the pixel stream transmitter: FSM states,
// default video timing constants and a ceil-log2 helper for port sizing.
package pix_stream_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VSYNC   = 3'd1,
    ST_V_BACK  = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_H_GAP   = 3'd4,
    ST_V_FRONT = 3'd5
  } tx_state_e;

  localparam int DEF_IMG_HDISP = 640;
  localparam int DEF_IMG_VDISP = 480;
  localparam int DEF_H_BLANK   = 16;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BLANK   = 4;

  // Number of bits needed to address 'value' locations (never below 1).
  function automatic int clog2_f(input int value);
    int bits;
    int v;
    bits = 0;
    v    = (value > 1) ? value - 1 : 0;
    while (v != 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/pix_tx_timing.sv
// Frame timing engine: walks vsync, back porch, active lines with
// optional per-pixel gaps, horizontal gaps and front porch, and issues
// one frame-memory read per active pixel in raster order.
module pix_tx_timing
  import pix_stream_tx_pkg::*;
#(
  parameter int IMG_HDISP = DEF_IMG_HDISP,
  parameter int IMG_VDISP = DEF_IMG_VDISP,
  parameter int H_BLANK   = DEF_H_BLANK,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BLANK   = DEF_V_BLANK,
  parameter int CLKEN_GAP = 0,
  parameter int ADDR_W    = 19
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_stb_o,
  output logic              line_act_o,
  output logic              vsync_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int COL_W   = $clog2(IMG_HDISP + 1);
  localparam int LINE_W  = $clog2(IMG_VDISP + 1);
  localparam int CNT_MAX = (V_SYNC > V_BLANK) ? ((V_SYNC > H_BLANK) ? V_SYNC : H_BLANK)
                                              : ((V_BLANK > H_BLANK) ? V_BLANK : H_BLANK);
  localparam int CNT_W   = $clog2(CNT_MAX + 2);
  localparam int GAP_W   = $clog2(CLKEN_GAP + 2);

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               stb_q, stb_d;
  logic               act_q, act_d;

  // State, counters and the read address/strobe registers; reset clears all.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      line_q  <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      stb_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      line_q  <= line_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      stb_q   <= stb_d;
      act_q   <= act_d;
    end
  end

  // Next-state logic; the address register only moves when a read is issued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    line_d  = line_q;
    gap_d   = gap_q;
    addr_d  = addr_q;
    stb_d   = 1'b0;
    act_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_VSYNC;
          cnt_d   = '0;
          col_d   = '0;
          line_d  = '0;
          gap_d   = '0;
        end
      end
      ST_VSYNC: begin
        if (cnt_q == CNT_W'(V_SYNC - 1)) begin
          state_d = ST_V_BACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_V_BACK: begin
        if (cnt_q == CNT_W'(V_BLANK - 1)) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        act_d = 1'b1;
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          stb_d  = 1'b1;
          addr_d = ADDR_W'(line_q) * ADDR_W'(IMG_HDISP) + ADDR_W'(col_q);
          if (col_q == COL_W'(IMG_HDISP - 1)) begin
            cnt_d   = '0;
            state_d = (line_q == LINE_W'(IMG_VDISP - 1)) ? ST_V_FRONT : ST_H_GAP;
          end else begin
            col_d = col_q + 1'b1;
            gap_d = GAP_W'(CLKEN_GAP);
          end
        end
      end
      ST_H_GAP: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          line_d  = line_q + 1'b1;
          col_d   = '0;
          gap_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_V_FRONT: begin
        if (cnt_q == CNT_W'(V_BLANK - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_addr_o    = addr_q;
  assign rd_stb_o     = stb_q;
  assign line_act_o   = act_q;
  assign vsync_o      = (state_q == ST_VSYNC);
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = (state_q == ST_V_FRONT) && (cnt_q == CNT_W'(V_BLANK - 1));

endmodule

// File: rtl/pix_stream_tx.sv
// Pixel stream transmitter top: reads a frame memory in raster order and
// emits a camera-style vsync/href/clken/Y stream. The only logic here is
// the register that lines href/clken up with the one-cycle memory latency.
module pix_stream_tx
  import pix_stream_tx_pkg::*;
#(
  parameter int IMG_HDISP  = DEF_IMG_HDISP,
  parameter int IMG_VDISP  = DEF_IMG_VDISP,
  parameter int H_BLANK    = DEF_H_BLANK,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BLANK    = DEF_V_BLANK,
  parameter int CLKEN_GAP  = 0,
  localparam int ADDR_W    = clog2_f(IMG_HDISP * IMG_VDISP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [7:0]        post_img_Y,
  output logic              busy,
  output logic              frame_done
);

  logic rd_stb;
  logic line_act;
  logic href_q, href_d;
  logic clken_q, clken_d;

  pix_tx_timing #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP),
    .H_BLANK   (H_BLANK),
    .V_SYNC    (V_SYNC),
    .V_BLANK   (V_BLANK),
    .CLKEN_GAP (CLKEN_GAP),
    .ADDR_W    (ADDR_W)
  ) u_timing (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .rd_addr_o    (mem_rd_addr),
    .rd_stb_o     (rd_stb),
    .line_act_o   (line_act),
    .vsync_o      (post_frame_vsync),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  assign href_d  = line_act;
  assign clken_d = rd_stb;

  // Delay href/clken by the memory read latency so they frame mem_rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_q  <= 1'b0;
      clken_q <= 1'b0;
    end else begin
      href_q  <= href_d;
      clken_q <= clken_d;
    end
  end

  assign post_frame_href  = href_q;
  assign post_frame_clken = clken_q;
  assign post_img_Y       = clken_q ? mem_rd_data : 8'd0;

endmodule
